adsr_env: RTL and testbench

- ADSR envelope generator that produces the 10-bit amplitude word for the `Amp` stage.
- Sits directly upstream of `Amp`: `out` drives `Amp.amp`, and the oscillator drives `Amp.in`.
- A `gate` input (note on/off) drives a 5-state machine that ramps a level register at a prescaled tick rate.
- All step, sustain and level values are unsigned, full-scale 2**NBITS-1.

---
 rtl/adsr_env_pkg.sv | 21 ++
 rtl/adsr_env_tick_gen.sv | 31 +++
 rtl/adsr_env.sv | 112 +++++++++++
 tb/tb_adsr_env.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adsr_env_pkg.sv
// synth_pkg: types and constants shared by the synth voice blocks.
// Provides env_state_t (IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4),
// the default level width SYNTH_NBITS, and env_max() for full-scale values.
package synth_pkg;

   localparam int SYNTH_NBITS = 10;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ATTACK  = 3'd1,
      DECAY   = 3'd2,
      SUSTAIN = 3'd3,
      RELEASE = 3'd4
   } env_state_t;

   // Full-scale unsigned value for a given width.
   function automatic int env_max(input int nbits);
      return (1 << nbits) - 1;
   endfunction

endpackage

// File: rtl/adsr_env_tick_gen.sv
// tick_gen: free-running prescaler that emits a one-cycle tick every TICK_DIV clocks.
// Ports: clk, rst (sync, active-high) in; tick out (high when count == TICK_DIV-1).
// The count is cleared only by rst; nothing else restarts it.
module tick_gen #(
   parameter int TICK_DIV = 1000
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   // Keep at least one bit so TICK_DIV=1 still elaborates.
   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   // With TICK_DIV=1 the count sits at 0 == LAST, so tick is high every clock.
   assign tick = (cnt == LAST);

endmodule

// File: rtl/adsr_env.sv
// adsr_env: ADSR envelope generator producing the amplitude word for the Amp stage.
// Ports: clk, rst (sync, active-high), gate, attack/decay/release steps, sustain_lvl in;
//        out (registered level), active (state != IDLE), stage (encoded state) out.
// Optional macro ADSR_HARD_RETRIG_EN: gate rise forces level to 0 (hard restart)
// instead of restarting ATTACK from the current level.
module adsr_env
   import synth_pkg::*;
#(
   parameter int NBITS    = SYNTH_NBITS,
   parameter int TICK_DIV = 1000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             gate,
   input  logic [NBITS-1:0] attack_step,
   input  logic [NBITS-1:0] decay_step,
   input  logic [NBITS-1:0] sustain_lvl,
   input  logic [NBITS-1:0] release_step,
   output logic [NBITS-1:0] out,
   output logic             active,
   output logic [2:0]       stage
);

   localparam logic [NBITS:0]   MAX_W = (NBITS+1)'(env_max(NBITS));
   localparam logic [NBITS-1:0] MAX   = MAX_W[NBITS-1:0];

   env_state_t       state;
   logic [NBITS-1:0] level;
   logic             gate_q;
   logic             tick;
   logic             rise;
   logic             fall;
   logic [NBITS:0]   attack_sum;
   logic [NBITS:0]   decay_floor;

   tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   assign rise = gate & ~gate_q;
   assign fall = ~gate & gate_q;

   // One extra bit so the saturation tests never see a wrapped sum.
   assign attack_sum  = {1'b0, level} + {1'b0, attack_step};
   assign decay_floor = {1'b0, sustain_lvl} + {1'b0, decay_step};

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         level  <= '0;
         gate_q <= 1'b0;
      end else begin
         gate_q <= gate;
         // Gate edges win over ticks: a state change cycle never also steps the level.
         if (rise) begin
            state <= ATTACK;
`ifdef ADSR_HARD_RETRIG_EN
            level <= '0;
`endif
         end else if (fall) begin
            if (state == ATTACK || state == DECAY || state == SUSTAIN) begin
               state <= RELEASE;
            end
         end else if (tick) begin
            case (state)
               IDLE: begin
                  level <= '0;
               end
               ATTACK: begin
                  if (attack_sum >= MAX_W) begin
                     level <= MAX;
                     state <= DECAY;
                  end else begin
                     level <= attack_sum[NBITS-1:0];
                  end
               end
               DECAY: begin
                  // Also covers sustain_lvl above the current level: jump up to it.
                  if ({1'b0, level} <= decay_floor) begin
                     level <= sustain_lvl;
                     state <= SUSTAIN;
                  end else begin
                     level <= level - decay_step;
                  end
               end
               SUSTAIN: begin
                  level <= sustain_lvl;
               end
               RELEASE: begin
                  if (level <= release_step) begin
                     level <= '0;
                     state <= IDLE;
                  end else begin
                     level <= level - release_step;
                  end
               end
               default: begin
                  level <= '0;
                  state <= IDLE;
               end
            endcase
         end
      end
   end

   assign out    = level;
   assign active = (state != IDLE);
   assign stage  = state;

endmodule

// File: tb/tb_adsr_env.sv
// tb_adsr_env: scoreboard bench for adsr_env with TICK_DIV=4 and TICK_DIV=1 instances
// sharing one set of inputs; a behavioural envelope model predicts every cycle.
// Honours ADSR_HARD_RETRIG_EN the same way as the design.
module tb_adsr_env;

   localparam int NB  = 10;
   localparam int MAXV = 1023;

   bit          clk = 1'b0;
   logic        rst;
   logic        gate;
   logic [9:0]  attack_step;
   logic [9:0]  decay_step;
   logic [9:0]  sustain_lvl;
   logic [9:0]  release_step;
   logic [9:0]  out4, out1;
   logic        active4, active1;
   logic [2:0]  stage4, stage1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   adsr_env #(.NBITS(NB), .TICK_DIV(4)) dut4 (
      .clk(clk), .rst(rst), .gate(gate),
      .attack_step(attack_step), .decay_step(decay_step),
      .sustain_lvl(sustain_lvl), .release_step(release_step),
      .out(out4), .active(active4), .stage(stage4)
   );

   adsr_env #(.NBITS(NB), .TICK_DIV(1)) dut1 (
      .clk(clk), .rst(rst), .gate(gate),
      .attack_step(attack_step), .decay_step(decay_step),
      .sustain_lvl(sustain_lvl), .release_step(release_step),
      .out(out1), .active(active1), .stage(stage1)
   );

   // ---------------- reference model ----------------
   // st: 0 idle, 1 attack, 2 decay, 3 sustain, 4 release
   typedef struct {
      int lvl;
      int st;
      bit gq;
      int cnt;
   } mdl_t;

   typedef struct {
      int o4;
      int s4;
      int o1;
      int s1;
   } exp_t;

   mdl_t m4, m1;
   exp_t sb[$];

   function automatic mdl_t mstep(mdl_t m, bit r, bit g, int a, int d, int s, int rl, int td);
      mdl_t n;
      bit   rise, fall, tick;
      n = m;
      if (r) begin
         n.lvl = 0; n.st = 0; n.gq = 1'b0; n.cnt = 0;
         return n;
      end
      rise  = g && !m.gq;
      fall  = !g && m.gq;
      tick  = (m.cnt == td - 1);
      n.gq  = g;
      n.cnt = (m.cnt + 1) % td;
      if (rise) begin
         n.st = 1;
`ifdef ADSR_HARD_RETRIG_EN
         n.lvl = 0;
`endif
      end else if (fall) begin
         if (m.st >= 1 && m.st <= 3) n.st = 4;
      end else if (tick) begin
         case (m.st)
            1: begin
               if (m.lvl + a >= MAXV) begin n.lvl = MAXV; n.st = 2; end
               else n.lvl = m.lvl + a;
            end
            2: begin
               if (m.lvl - d <= s) begin n.lvl = s; n.st = 3; end
               else n.lvl = m.lvl - d;
            end
            3: n.lvl = s;
            4: begin
               if (m.lvl - rl <= 0) begin n.lvl = 0; n.st = 0; end
               else n.lvl = m.lvl - rl;
            end
            default: n.lvl = 0;
         endcase
      end
      return n;
   endfunction

   function automatic void cmp(string nm, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
      end
   endfunction

   // Advance one clock: predict post-edge outputs from current inputs, then wait.
   task automatic cyc();
      exp_t e;
      m4 = mstep(m4, rst, gate, int'(attack_step), int'(decay_step), int'(sustain_lvl),
                 int'(release_step), 4);
      m1 = mstep(m1, rst, gate, int'(attack_step), int'(decay_step), int'(sustain_lvl),
                 int'(release_step), 1);
      e.o4 = m4.lvl; e.s4 = m4.st; e.o1 = m1.lvl; e.s1 = m1.st;
      sb.push_back(e);
      @(negedge clk);
   endtask

   task automatic wait_stage(int s, int lim, string nm);
      int k;
      k = 0;
      while (int'(stage4) != s && k < lim) begin
         cyc();
         k++;
      end
      cmp(nm, int'(stage4), s);
   endtask

   function automatic logic [9:0] rnd_step();
      case ($urandom_range(0, 3))
         0:       return 10'd0;
         1:       return 10'd1023;
         2:       return 10'($urandom_range(1, 64));
         default: return 10'($urandom_range(0, 1023));
      endcase
   endfunction

   // ---------------- monitor ----------------
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            cmp("out4",    int'(out4),    e.o4);
            cmp("stage4",  int'(stage4),  e.s4);
            cmp("active4", int'(active4), int'(e.s4 != 0));
            cmp("out1",    int'(out1),    e.o1);
            cmp("stage1",  int'(stage1),  e.s1);
            cmp("active1", int'(active1), int'(e.s1 != 0));
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int lv;
      m4 = '{0, 0, 1'b0, 0};
      m1 = '{0, 0, 1'b0, 0};
      rst = 1'b1; gate = 1'b1;
      attack_step = 10'd256; decay_step = 10'd128;
      sustain_lvl = 10'd512; release_step = 10'd64;

      // Reset held with gate high, then ATTACK once released.
      repeat (3) cyc();
      cmp("rst_out", int'(out4), 0);
      cmp("rst_stage", int'(stage4), 0);
      rst = 1'b0;
      repeat (2) cyc();
      cmp("rst_to_attack", int'(stage4), 1);

      // Full ADSR cycle.
      wait_stage(3, 400, "adsr_reach_sustain");
      cmp("adsr_sustain_out", int'(out4), 512);
      gate = 1'b0;
      cyc();
      cmp("adsr_release_stage", int'(stage4), 4);
      wait_stage(0, 400, "adsr_reach_idle");
      cmp("adsr_idle_out", int'(out4), 0);

      // Early release at 512 during ATTACK.
      gate = 1'b1;
      begin
         int k;
         k = 0;
         while (!(out4 == 10'd512 && stage4 == 3'd1) && k < 100) begin cyc(); k++; end
      end
      cmp("early_at_512", int'(out4), 512);
      gate = 1'b0;
      cyc();
      cmp("early_stage", int'(stage4), 4);
      cmp("early_out_hold", int'(out4), 512);
      wait_stage(0, 400, "early_idle");

      // Retrigger from RELEASE at 300.
      sustain_lvl = 10'd300;
      gate = 1'b1;
      wait_stage(3, 400, "retrig_sustain");
      gate = 1'b0;
      cyc();
      cmp("retrig_release", int'(stage4), 4);
      gate = 1'b1;
      cyc();
      cmp("retrig_stage", int'(stage4), 1);
`ifdef ADSR_HARD_RETRIG_EN
      cmp("retrig_out", int'(out4), 0);
`else
      cmp("retrig_out", int'(out4), 300);
`endif
      repeat (8) cyc();
      gate = 1'b0;
      wait_stage(0, 400, "retrig_idle");

      // attack_step=0 freezes ATTACK for 100 ticks.
      attack_step = 10'd0;
      gate = 1'b1;
      repeat (400) cyc();
      cmp("a0_out", int'(out4), 0);
      cmp("a0_stage", int'(stage4), 1);
      gate = 1'b0;
      wait_stage(0, 40, "a0_idle");

      // sustain=1023: DECAY exits on its first tick at 1023.
      attack_step = 10'd256; sustain_lvl = 10'd1023;
      gate = 1'b1;
      wait_stage(2, 100, "s_max_decay");
      cmp("s_max_peak", int'(out4), 1023);
      repeat (4) cyc();
      cmp("s_max_sustain", int'(stage4), 3);
      cmp("s_max_out", int'(out4), 1023);

      // release_step=1023: IDLE on the first RELEASE tick.
      release_step = 10'd1023;
      gate = 1'b0;
      cyc();
      cmp("r_max_release", int'(stage4), 4);
      repeat (4) cyc();
      cmp("r_max_idle", int'(stage4), 0);

      // Gate fall on the exact tick cycle in DECAY.
      attack_step = 10'd1023; decay_step = 10'd1; sustain_lvl = 10'd0;
      gate = 1'b1;
      wait_stage(2, 100, "fot_decay");
      repeat (5) cyc();
      while (m4.cnt != 3) cyc();
      lv = m4.lvl;
      gate = 1'b0;
      cyc();
      cmp("fot_stage", int'(stage4), 4);
      cmp("fot_out", int'(out4), lv);
      wait_stage(0, 40, "fot_idle");

      // Reset mid-envelope.
      attack_step = 10'd64;
      gate = 1'b1;
      repeat (10) cyc();
      rst = 1'b1;
      cyc();
      cmp("midrst_out", int'(out4), 0);
      rst = 1'b0;

      // Randomised traffic.
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 39) == 0) gate = ~gate;
         if ($urandom_range(0, 15) == 0) attack_step  = rnd_step();
         if ($urandom_range(0, 15) == 0) decay_step   = rnd_step();
         if ($urandom_range(0, 15) == 0) sustain_lvl  = rnd_step();
         if ($urandom_range(0, 15) == 0) release_step = rnd_step();
         rst = ($urandom_range(0, 799) == 0);
         cyc();
      end
      rst = 1'b0;
      gate = 1'b0;
      repeat (4) cyc();

      #2;
      cmp("sb_drain", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
